// File: rtl/orig_pixel_server.sv
// Original-image frame store: sequential frame load, then pipelined read service
// with a fixed LATENCY, a saturating served-read counter and a sticky misuse flag.
module orig_pixel_server #(
  parameter int unsigned DEPTH   = 16384,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [23:0] load_data,
  output logic        load_busy,
  input  logic        request,
  input  logic [13:0] orig_addr,
  output logic [23:0] orig_data,
  output logic        orig_ready,
  output logic [14:0] served_cnt,
  output logic        err
);

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 24;
  localparam int unsigned CW = 15;
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(16384);
  localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SERVE} state_t;

  state_t              state;
  logic [AW-1:0]       ptr;
  logic [DW-1:0]       mem [DEPTH];
  logic [LATENCY-1:0]  pv;
  logic [DW-1:0]       pd [LATENCY];

  logic                in_range_c;
  logic [DW-1:0]       rd_word_c;
  logic                pipe_empty_c;
  logic                wr_en_c;
  logic                accept_c;

  assign in_range_c   = {1'b0, orig_addr} < DEPTH_W;
  assign rd_word_c    = in_range_c ? mem[orig_addr[IW-1:0]] : '0;
  assign pipe_empty_c = ~|pv;
  assign accept_c     = (state == SERVE) && request;
  // A restart in the same cycle discards the data word.
  assign wr_en_c      = rst && (state == LOAD) && load_valid && !load_start;

  always_ff @(posedge clk) begin
    if (wr_en_c) mem[ptr[IW-1:0]] <= load_data;
  end

  // Read pipeline; invalid slots carry zero so the output never shows stale data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pv <= '0;
      for (int i = 0; i < int'(LATENCY); i++) pd[i] <= '0;
    end else begin
      pv[0] <= accept_c;
      pd[0] <= accept_c ? rd_word_c : '0;
      for (int i = 1; i < int'(LATENCY); i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign orig_ready = pv[LATENCY-1];
  assign orig_data  = pd[LATENCY-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= '0;
      load_busy  <= 1'b0;
      served_cnt <= '0;
      err        <= 1'b0;
    end else begin
      if (orig_ready && (served_cnt != CNT_MAX)) served_cnt <= served_cnt + CW'(1);
      case (state)
        IDLE: begin
          if (request) err <= 1'b1;
          if (load_start) begin
            state     <= LOAD;
            ptr       <= '0;
            load_busy <= 1'b1;
          end
        end
        LOAD: begin
          if (request) err <= 1'b1;
          if (load_start) begin
            ptr <= '0;
          end else if (load_valid) begin
            if (ptr == LAST) begin
              state      <= SERVE;
              ptr        <= '0;
              served_cnt <= '0;
              load_busy  <= 1'b0;
            end else begin
              ptr <= ptr + AW'(1);
            end
          end
        end
        SERVE: begin
          if (request && !in_range_c) err <= 1'b1;
          // Reload only once every in-flight read has drained.
          if (load_start) begin
            if (pipe_empty_c && !request) begin
              state     <= LOAD;
              ptr       <= '0;
              load_busy <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_orig_pixel_server.sv
// Scoreboard bench for orig_pixel_server: three instances cover full-depth LATENCY=1,
// small-depth LATENCY=3 corner cases, and reset abort at LATENCY=2.
module tb_orig_pixel_server;

  localparam int DA = 16384;
  localparam int DB = 1024;
  localparam int DC = 16;

  typedef struct packed {
    logic [23:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int unsigned vecs = 0;
  int unsigned errs = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  logic        a_rst, a_ls, a_lv, a_busy, a_req, a_rdy, a_err;
  logic [23:0] a_ld, a_data;
  logic [13:0] a_addr;
  logic [14:0] a_srv;
  logic        b_rst, b_ls, b_lv, b_busy, b_req, b_rdy, b_err;
  logic [23:0] b_ld, b_data;
  logic [13:0] b_addr;
  logic [14:0] b_srv;
  logic        c_rst, c_ls, c_lv, c_busy, c_req, c_rdy, c_err;
  logic [23:0] c_ld, c_data;
  logic [13:0] c_addr;
  logic [14:0] c_srv;

  orig_pixel_server #(.DEPTH(DA), .LATENCY(1)) u_a (
    .clk(clk), .rst(a_rst), .load_start(a_ls), .load_valid(a_lv), .load_data(a_ld),
    .load_busy(a_busy), .request(a_req), .orig_addr(a_addr), .orig_data(a_data),
    .orig_ready(a_rdy), .served_cnt(a_srv), .err(a_err));

  orig_pixel_server #(.DEPTH(DB), .LATENCY(3)) u_b (
    .clk(clk), .rst(b_rst), .load_start(b_ls), .load_valid(b_lv), .load_data(b_ld),
    .load_busy(b_busy), .request(b_req), .orig_addr(b_addr), .orig_data(b_data),
    .orig_ready(b_rdy), .served_cnt(b_srv), .err(b_err));

  orig_pixel_server #(.DEPTH(DC), .LATENCY(2)) u_c (
    .clk(clk), .rst(c_rst), .load_start(c_ls), .load_valid(c_lv), .load_data(c_ld),
    .load_busy(c_busy), .request(c_req), .orig_addr(c_addr), .orig_data(c_data),
    .orig_ready(c_rdy), .served_cnt(c_srv), .err(c_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] pix(input int i);
    logic [13:0] a;
    a = 14'(i);
    return {a[7:0], ~a[7:0], a[13:6]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Response monitors: every ready pops the oldest expectation and checks data and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (a_rdy) begin
      if (qa.size() == 0) begin
        vecs++; errs++;
        $display("FAIL a_spurious_ready: got data %h at cycle %0d, required no response", a_data, cyc);
      end else begin
        e = qa.pop_front();
        chk("a_data", 32'(a_data), 32'(e.data));
        chk("a_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else chk("a_quiet_data", 32'(a_data), 32'h0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_rdy) begin
      if (qb.size() == 0) begin
        vecs++; errs++;
        $display("FAIL b_spurious_ready: got data %h at cycle %0d, required no response", b_data, cyc);
      end else begin
        e = qb.pop_front();
        chk("b_data", 32'(b_data), 32'(e.data));
        chk("b_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else chk("b_quiet_data", 32'(b_data), 32'h0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (c_rdy) begin
      if (qc.size() == 0) begin
        vecs++; errs++;
        $display("FAIL c_spurious_ready: got data %h at cycle %0d, required no response", c_data, cyc);
      end else begin
        e = qc.pop_front();
        chk("c_data", 32'(c_data), 32'(e.data));
        chk("c_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else chk("c_quiet_data", 32'(c_data), 32'h0);
  end

  task automatic b_load();
    b_ls = 1'b1; tick(); b_ls = 1'b0;
    for (int i = 0; i < DB; i++) begin
      b_lv = 1'b1; b_ld = pix(i); tick();
    end
    b_lv = 1'b0;
    chk("b_load_done_busy", 32'(b_busy), 32'h0);
  endtask

  task automatic b_reset();
    b_rst = 1'b0; tick(); b_rst = 1'b1;
    chk("b_reset_err", 32'(b_err), 32'h0);
  endtask

  initial begin
    {a_rst, a_ls, a_lv, a_req} = '0; a_ld = '0; a_addr = '0;
    {b_rst, b_ls, b_lv, b_req} = '0; b_ld = '0; b_addr = '0;
    {c_rst, c_ls, c_lv, c_req} = '0; c_ld = '0; c_addr = '0;
    tick(2);
    chk("a_rst_busy", 32'(a_busy), 32'h0);
    chk("a_rst_srv", 32'(a_srv), 32'h0);
    chk("a_rst_err", 32'(a_err), 32'h0);
    chk("b_rst_rdy", 32'(b_rdy), 32'h0);
    chk("c_rst_err", 32'(c_err), 32'h0);
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;

    // Full-depth load and sweep at LATENCY=1.
    a_ls = 1'b1; tick(); a_ls = 1'b0;
    chk("a_load_busy", 32'(a_busy), 32'h1);
    for (int i = 0; i < DA; i++) begin
      if (i == DA - 1) chk("a_busy_before_last", 32'(a_busy), 32'h1);
      a_lv = 1'b1; a_ld = pix(i); tick();
    end
    a_lv = 1'b0;
    chk("a_serve_busy", 32'(a_busy), 32'h0);
    chk("a_serve_srv", 32'(a_srv), 32'h0);
    for (int i = 0; i < DA; i++) begin
      a_req = 1'b1; a_addr = 14'(i);
      qa.push_back('{pix(i), cyc + 1});
      tick();
    end
    a_req = 1'b0;
    tick(3);
    chk("a_served_total", 32'(a_srv), 32'd16384);
    chk("a_err_clean", 32'(a_err), 32'h0);

    // Request in IDLE is dropped and flagged.
    b_req = 1'b1; b_addr = 14'd0; tick(); b_req = 1'b0; tick(4);
    chk("b_idle_req_err", 32'(b_err), 32'h1);
    b_reset();

    // Requests in LOAD with load_valid 1,0,1: exactly two words written.
    b_ls = 1'b1; tick(); b_ls = 1'b0;
    chk("b_load_busy", 32'(b_busy), 32'h1);
    b_req = 1'b1; b_addr = 14'd7;
    b_lv = 1'b1; b_ld = pix(0); tick();
    b_lv = 1'b0; b_ld = 24'hdeadbe; tick();
    b_lv = 1'b1; b_ld = pix(1); tick();
    b_req = 1'b0;
    for (int i = 2; i < DB; i++) begin
      if (i == DB - 1) chk("b_busy_before_last", 32'(b_busy), 32'h1);
      b_lv = 1'b1; b_ld = pix(i); tick();
    end
    b_lv = 1'b0;
    chk("b_busy_after_last", 32'(b_busy), 32'h0);
    chk("b_load_req_err", 32'(b_err), 32'h1);
    b_req = 1'b1; b_addr = 14'd0; qb.push_back('{pix(0), cyc + 3}); tick();
    b_addr = 14'd1; qb.push_back('{pix(1), cyc + 3}); tick();
    b_req = 1'b0; tick(5);
    b_reset();

    // LATENCY=3 ordering: 5, 5, 100 back to back.
    b_load();
    b_req = 1'b1;
    b_addr = 14'd5;   qb.push_back('{pix(5), cyc + 3});   tick();
    b_addr = 14'd5;   qb.push_back('{pix(5), cyc + 3});   tick();
    b_addr = 14'd100; qb.push_back('{pix(100), cyc + 3}); tick();
    b_req = 1'b0; tick(5);
    chk("b_lat_srv", 32'(b_srv), 32'd3);
    chk("b_lat_err", 32'(b_err), 32'h0);

    // Out-of-range address returns zero with ready and flags err.
    b_req = 1'b1; b_addr = 14'd2000; qb.push_back('{24'h0, cyc + 3}); tick();
    b_req = 1'b0; tick(5);
    chk("b_oor_err", 32'(b_err), 32'h1);
    chk("b_oor_srv", 32'(b_srv), 32'd4);
    b_reset();

    // load_start with a read in flight is refused; with empty pipeline it is taken.
    b_load();
    b_req = 1'b1; b_addr = 14'd9; qb.push_back('{pix(9), cyc + 3}); tick();
    b_req = 1'b0; b_ls = 1'b1; tick(); b_ls = 1'b0;
    chk("b_busy_refused", 32'(b_busy), 32'h0);
    chk("b_refused_err", 32'(b_err), 32'h1);
    tick(5);
    chk("b_refused_srv", 32'(b_srv), 32'd1);
    b_ls = 1'b1; tick(); b_ls = 1'b0;
    chk("b_busy_taken", 32'(b_busy), 32'h1);

    // Reset during SERVE at LATENCY=2 aborts in-flight reads.
    c_ls = 1'b1; tick(); c_ls = 1'b0;
    for (int i = 0; i < DC; i++) begin
      c_lv = 1'b1; c_ld = pix(i); tick();
    end
    c_lv = 1'b0;
    chk("c_serve_busy", 32'(c_busy), 32'h0);
    c_req = 1'b1; c_addr = 14'd3; qc.push_back('{pix(3), cyc + 2}); tick();
    c_addr = 14'd4; tick();
    c_rst = 1'b0; c_addr = 14'd5; tick();
    c_rst = 1'b1; c_addr = 14'd6;
    chk("c_after_rst_rdy", 32'(c_rdy), 32'h0);
    chk("c_after_rst_data", 32'(c_data), 32'h0);
    chk("c_after_rst_busy", 32'(c_busy), 32'h0);
    chk("c_after_rst_srv", 32'(c_srv), 32'h0);
    chk("c_after_rst_err", 32'(c_err), 32'h0);
    tick(); c_req = 1'b0; tick(4);
    chk("c_idle_req_err", 32'(c_err), 32'h1);
    chk("c_idle_srv", 32'(c_srv), 32'h0);
    c_ls = 1'b1; tick(); c_ls = 1'b0;
    chk("c_idle_to_load", 32'(c_busy), 32'h1);

    tick(5);
    chk("a_queue_drained", 32'(qa.size()), 32'h0);
    chk("b_queue_drained", 32'(qb.size()), 32'h0);
    chk("c_queue_drained", 32'(qc.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
